photon_bin_sequencer: RTL and testbench
=======================================

// Module: photon_bin_sequencer
// PURPOSE
//  Sequences time-binned photon counting on top of the free-running photon counter.
//  Splits a run into NUM_BINS consecutive windows of WIN_CYCLES clocks each.
//  Each bin count is the modulo difference of g_photon_cnt between window edges,
//  so no counts are lost and the counter is never cleared during a run.
//  Bins are delivered over a valid/ready stream to the readout/FIFO logic.
// PARAMETERS
//  COUNTSIZE  32  width of g_photon_cnt and bin_data
//  WIN_W      24  width of win_cycles and of the window timer
//  BIN_W      16  width of num_bins and bin_idx
//  DROP_W     16  width of drop_cnt (saturating)
// PORTS
//  g_clk        in   1          system clock
//  g_rst        in   1          asynchronous, active-high reset
//  start        in   1          1-cycle run request; honoured only in IDLE
//  abort        in   1          stop the run; any state -> IDLE
//  win_cycles   in   WIN_W      window length in clocks; 0 treated as 1
//  num_bins     in   BIN_W      bins per run; 0 = continuous until abort
//  photon_cnt   in   COUNTSIZE  free-running count from the photon counter
//  bin_data     out  COUNTSIZE  photon count of the bin
//  bin_idx      out  BIN_W      bin index within the run, from 0
//  bin_last     out  1          marks the final bin of a finite run
//  bin_valid    out  1          stream valid
//  bin_ready    in   1          stream ready
//  busy         out  1          high in every state except IDLE
//  done         out  1          1-cycle pulse at normal run completion
//  drop_cnt     out  DROP_W     bins lost to backpressure; cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including bin_valid, done, drop_cnt and
//   the internal timer, base, len and bin counter. Reset mid-run abandons the run.
//  States: IDLE, RUN, DRAIN.
//  IDLE + start (abort low):
//   - latch len = max(win_cycles,1) and nb = num_bins
//   - base <= photon_cnt; timer <= 0; bin counter <= 0; drop_cnt <= 0
//   - go to RUN. Later changes to win_cycles/num_bins do not affect the run.
//  RUN: timer increments each cycle. On the boundary cycle (timer == len-1):
//   - delta = photon_cnt - base, mod 2^COUNTSIZE (handles counter wrap)
//   - base <= photon_cnt; timer <= 0
//   - the boundary sample ends one bin and starts the next, so bins are contiguous
//  Output register:
//   - Load delta when !bin_valid or bin_ready in the boundary cycle.
//   - After a load, bin_valid is high from the next cycle (latency 1).
//   - Held stable until the bin_valid & bin_ready handshake.
//   - If the register is occupied and not accepted at a boundary, the bin is
//     dropped: drop_cnt +1, saturating at all-ones.
//   - bin_idx advances per bin, whether delivered or dropped.
//   - Handshake with no new load: bin_valid <= 0.
//  Finite run (nb != 0), boundary of bin nb-1:
//   - that bin carries bin_last=1; go to DRAIN
//   - DRAIN waits until bin_valid==0, then pulses done for 1 cycle -> IDLE
//   - a dropped last bin still ends the run
//  Continuous run (nb == 0): bin_last=0 always; bin_idx wraps mod 2^BIN_W.
//  abort (priority over start and boundary): next state IDLE; bin_valid <= 0;
//   no done pulse; drop_cnt is kept.
//  start while busy is ignored.
//  len=1: every RUN cycle is a boundary.
// TESTING
//  T1 photon_cnt +1/clk, win=10, bins=3, ready=1 -> bin_data 10,10,10 with idx
//     0,1,2; last on idx 2; done 1 cycle after the last handshake; busy low after.
//  T2 photon_cnt starts at 0xFFFF_FFFD, +1/clk, win=5, bins=2 -> bin_data 5,5
//     (wrap), drop_cnt=0.
//  T3 win=10, bins=4, +1/clk, ready=0 for the first 35 cycles after start ->
//     bins 1 and 2 dropped, drop_cnt=2; first bin held stable (10, idx 0), then
//     idx 3 (bin_data 10, last=1); done pulses.
//  T4 abort at cycle 15 of win=10, bins=5 run -> bin_valid low next cycle, IDLE,
//     no done; a new start gives idx 0 with a correct delta.
//  T5 win=0, bins=4, +2/clk -> 4 bins on consecutive cycles, each 2; start
//     pulsed mid-run ignored.
//  T6 assert g_rst mid-RUN with bin_valid high -> all outputs 0 immediately; after
//     release the block stays IDLE until start.

Source files
------------

// File: rtl/photon_bin_if.sv
// Bin stream from photon_bin_sequencer to the readout/FIFO logic.
// Each beat carries a bin count, its index within the run, and a last-bin flag.
interface photon_bin_if #(
    parameter int COUNTSIZE = 32,
    parameter int BIN_W     = 16
);
    logic [COUNTSIZE-1:0] bin_data;
    logic [BIN_W-1:0]     bin_idx;
    logic                 bin_last;
    logic                 bin_valid;
    logic                 bin_ready;

    modport master (
        output bin_data, bin_idx, bin_last, bin_valid,
        input  bin_ready
    );

    modport slave (
        input  bin_data, bin_idx, bin_last, bin_valid,
        output bin_ready
    );
endinterface

// File: rtl/photon_bin_sequencer.sv
// Splits a counting run into fixed-length windows and streams each window's photon count,
// taken as the modulo difference of the free-running counter between window edges.
module photon_bin_sequencer #(
    parameter int COUNTSIZE = 32,
    parameter int WIN_W     = 24,
    parameter int BIN_W     = 16,
    parameter int DROP_W    = 16
) (
    input  logic                 g_clk,
    input  logic                 g_rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIN_W-1:0]     win_cycles,
    input  logic [BIN_W-1:0]     num_bins,
    input  logic [COUNTSIZE-1:0] photon_cnt,
    photon_bin_if.master         bin,
    output logic                 busy,
    output logic                 done,
    output logic [DROP_W-1:0]    drop_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [WIN_W-1:0]  WIN_ONE  = {{(WIN_W-1){1'b0}}, 1'b1};
    localparam logic [BIN_W-1:0]  BIN_ONE  = {{(BIN_W-1){1'b0}}, 1'b1};
    localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_ONE;
    endfunction

    state_t               state, state_nxt;
    logic [WIN_W-1:0]     win_len;
    logic [WIN_W-1:0]     win_timer;
    logic [BIN_W-1:0]     run_bins;
    logic [BIN_W-1:0]     bin_cnt;
    logic [COUNTSIZE-1:0] base_cnt;

    logic                 start_go;
    logic                 boundary;
    logic                 is_last;
    logic                 handshake;
    logic                 load_bin;
    logic                 drop_bin;
    logic [COUNTSIZE-1:0] delta;

    assign start_go  = (state == IDLE) && start && !abort;
    assign boundary  = (state == RUN) && (win_timer == win_len - WIN_ONE);
    assign is_last   = (run_bins != '0) && (bin_cnt == run_bins - BIN_ONE);
    assign handshake = bin.bin_valid && bin.bin_ready;
    // The output register frees up in the same cycle it is accepted, so a
    // boundary coinciding with a handshake still delivers its bin.
    assign load_bin  = boundary && (!bin.bin_valid || bin.bin_ready);
    assign drop_bin  = boundary && !load_bin;
    // Unsigned modulo subtraction absorbs a counter wrap inside the window.
    assign delta     = photon_cnt - base_cnt;

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE:  if (start_go) state_nxt = RUN;
            RUN: begin
                if (abort)                    state_nxt = IDLE;
                else if (boundary && is_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (abort) state_nxt = IDLE;
                else if (!bin.bin_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_rst) begin
        if (g_rst) begin
            win_len       <= '0;
            win_timer     <= '0;
            run_bins      <= '0;
            bin_cnt       <= '0;
            base_cnt      <= '0;
            drop_cnt      <= '0;
            bin.bin_data  <= '0;
            bin.bin_idx   <= '0;
            bin.bin_last  <= 1'b0;
            bin.bin_valid <= 1'b0;
        end else begin
            if (start_go) begin
                win_len   <= (win_cycles == '0) ? WIN_ONE : win_cycles;
                run_bins  <= num_bins;
                base_cnt  <= photon_cnt;
                win_timer <= '0;
                bin_cnt   <= '0;
                drop_cnt  <= '0;
            end else if ((state == RUN) && !abort) begin
                if (boundary) begin
                    base_cnt  <= photon_cnt;
                    win_timer <= '0;
                    bin_cnt   <= bin_cnt + BIN_ONE;
                end else begin
                    win_timer <= win_timer + WIN_ONE;
                end
            end

            if (abort) begin
                bin.bin_valid <= 1'b0;
            end else if (load_bin) begin
                bin.bin_data  <= delta;
                bin.bin_idx   <= bin_cnt;
                bin.bin_last  <= is_last;
                bin.bin_valid <= 1'b1;
            end else if (handshake) begin
                bin.bin_valid <= 1'b0;
            end

            if (drop_bin && !abort) drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_photon_bin_sequencer.sv
// Scoreboard bench for photon_bin_sequencer: a cycle-stepped reference model predicts
// delivered bins, busy/done/drop_cnt, and a negedge monitor compares them.
module tb_photon_bin_sequencer;
    localparam int CS = 32;
    localparam int WW = 24;
    localparam int BW = 16;
    localparam int DW = 16;

    logic          g_clk = 1'b0;
    logic          g_rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [WW-1:0] win_cycles = '0;
    logic [BW-1:0] num_bins = '0;
    logic [CS-1:0] photon_cnt = '0;
    logic          busy, done;
    logic [DW-1:0] drop_cnt;

    photon_bin_if #(.COUNTSIZE(CS), .BIN_W(BW)) bus ();

    photon_bin_sequencer #(.COUNTSIZE(CS), .WIN_W(WW), .BIN_W(BW), .DROP_W(DW)) dut (
        .g_clk      (g_clk),
        .g_rst      (g_rst),
        .start      (start),
        .abort      (abort),
        .win_cycles (win_cycles),
        .num_bins   (num_bins),
        .photon_cnt (photon_cnt),
        .bin        (bus.master),
        .busy       (busy),
        .done       (done),
        .drop_cnt   (drop_cnt)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic [CS-1:0] data;
        logic [BW-1:0] idx;
        logic          last;
    } bin_t;

    bin_t sb[$];
    bin_t seen[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // reference model state: run phase, window length, elapsed cycles, pending slot
    bit            m_run = 0, m_drain = 0, m_slot = 0;
    int            m_L = 1, m_nb = 0, m_el = 0, m_drops = 0;
    logic [CS-1:0] m_wstart = '0;
    logic          exp_valid = 0, exp_busy = 0, exp_done = 0;
    logic [DW-1:0] exp_drop = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_drain = 0; m_slot = 0; m_el = 0; m_drops = 0;
        exp_valid = 0; exp_busy = 0; exp_done = 0; exp_drop = '0;
        sb.delete();
    endtask

    // Predicts this cycle's outputs, then what the coming clock edge does.
    task automatic model_step(input bit st, input bit ab, input bit rdy, input logic [CS-1:0] pc);
        int   k;
        bit   lst;
        bin_t b;
        exp_valid = m_slot;
        exp_busy  = m_run || m_drain;
        exp_done  = m_drain && !m_slot && !ab;
        exp_drop  = 16'(m_drops);
        if (ab) begin
            if (m_slot && !rdy) void'(sb.pop_back());
            m_run = 0; m_drain = 0; m_slot = 0;
        end else if (!m_run && !m_drain) begin
            if (st) begin
                m_run = 1;
                m_L = (win_cycles == '0) ? 1 : int'(win_cycles);
                m_nb = int'(num_bins);
                m_wstart = pc; m_el = 0; m_drops = 0;
            end
        end else if (m_run) begin
            if ((m_el % m_L) == m_L - 1) begin
                k = m_el / m_L;
                lst = (m_nb != 0) && (k + 1 == m_nb);
                b.data = pc - m_wstart;
                b.idx  = k[BW-1:0];
                b.last = lst;
                m_wstart = pc;
                if (!m_slot || rdy) begin
                    sb.push_back(b);
                    m_slot = 1;
                end else if (m_drops < 65535) begin
                    m_drops++;
                end
                if (lst) begin m_run = 0; m_drain = 1; end
            end else if (m_slot && rdy) begin
                m_slot = 0;
            end
            m_el++;
        end else begin
            if (!m_slot) m_drain = 0;
            else if (rdy) m_slot = 0;
        end
    endtask

    task automatic step(input bit st, input bit ab, input bit rdy, input logic [CS-1:0] inc);
        start = st; abort = ab; bus.bin_ready = rdy;
        photon_cnt = photon_cnt + inc;
        model_step(st, ab, rdy, photon_cnt);
        @(posedge g_clk); #1;
    endtask

    task automatic run_out(input int max, input int rpct, input logic [CS-1:0] inc);
        int c = 0;
        while ((m_run || m_drain) && c < max) begin
            step(0, 0, ($urandom_range(0, 99) < rpct), inc);
            c++;
        end
        if (m_run || m_drain) begin
            n_checks++; n_fail++;
            $display("FAIL run_timeout: still busy after %0d cycles", c);
            step(0, 1, 1, inc);
        end
        step(0, 0, 1, inc);
        chk("sb_drained", 32'(sb.size()), 0);
    endtask

    task automatic chk_seen(input string nm, input int i, input logic [CS-1:0] d,
                            input int idx, input bit lst);
        if (i < seen.size()) begin
            chk({nm, "_data"}, seen[i].data, d);
            chk({nm, "_idx"}, 32'(seen[i].idx), 32'(idx));
            chk({nm, "_last"}, 32'(seen[i].last), 32'(lst));
        end else begin
            n_checks++; n_fail++;
            $display("FAIL %s_missing: bin %0d got none expected one", nm, i);
        end
    endtask

    always @(negedge g_clk) begin
        bin_t e;
        bin_t a;
        chk("bin_valid", 32'(bus.bin_valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
        if (bus.bin_valid && bus.bin_ready) begin
            a.data = bus.bin_data; a.idx = bus.bin_idx; a.last = bus.bin_last;
            seen.push_back(a);
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_bin: got data %0h idx %0d expected no bin", a.data, a.idx);
            end else begin
                e = sb.pop_front();
                chk("bin_data", a.data, e.data);
                chk("bin_idx", 32'(a.idx), 32'(e.idx));
                chk("bin_last", 32'(a.last), 32'(e.last));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        int rp;
        bus.bin_ready = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        chk("rst_valid", 32'(bus.bin_valid), 0);
        chk("rst_data", bus.bin_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        g_rst = 1'b0;
        model_reset();
        repeat (2) step(0, 0, 1, 1);

        // T1: three 10-cycle windows, always ready
        win_cycles = 10; num_bins = 3; seen.delete();
        step(1, 0, 1, 1);
        run_out(200, 100, 1);
        chk("t1_count", 32'(seen.size()), 3);
        for (int i = 0; i < 3; i++) chk_seen("t1", i, 10, i, i == 2);

        // T2: counter wraps inside the run
        photon_cnt = 32'hFFFF_FFFC; win_cycles = 5; num_bins = 2; seen.delete();
        step(1, 0, 1, 1);
        run_out(200, 100, 1);
        chk("t2_count", 32'(seen.size()), 2);
        for (int i = 0; i < 2; i++) chk_seen("t2", i, 5, i, i == 1);
        chk("t2_drop", 32'(drop_cnt), 0);

        // T3: backpressure drops the middle bins
        win_cycles = 10; num_bins = 4; seen.delete();
        step(1, 0, 0, 1);
        repeat (35) step(0, 0, 0, 1);
        run_out(200, 100, 1);
        chk("t3_count", 32'(seen.size()), 2);
        chk_seen("t3a", 0, 10, 0, 0);
        chk_seen("t3b", 1, 10, 3, 1);
        chk("t3_drop", 32'(drop_cnt), 2);

        // T4: abort mid-run, then a fresh run
        win_cycles = 10; num_bins = 5; seen.delete();
        step(1, 0, 1, 1);
        repeat (14) step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        repeat (3) step(0, 0, 1, 1);
        chk("t4_count", 32'(seen.size()), 1);
        chk("t4_busy", 32'(busy), 0);
        win_cycles = 4; num_bins = 2; seen.delete();
        step(1, 0, 1, 1);
        run_out(200, 100, 1);
        chk_seen("t4n", 0, 4, 0, 0);

        // T5: zero window length means one bin per cycle; start mid-run ignored
        win_cycles = 0; num_bins = 4; seen.delete();
        step(1, 0, 1, 2);
        step(0, 0, 1, 2);
        step(1, 0, 1, 2);
        run_out(200, 100, 2);
        chk("t5_count", 32'(seen.size()), 4);
        for (int i = 0; i < 4; i++) chk_seen("t5", i, 2, i, i == 3);

        // T6: asynchronous reset while a bin is pending
        win_cycles = 3; num_bins = 0;
        step(1, 0, 0, 1);
        repeat (5) step(0, 0, 0, 1);
        chk("t6_pending", 32'(bus.bin_valid), 1);
        g_rst = 1'b1;
        #1;
        chk("t6_valid", 32'(bus.bin_valid), 0);
        chk("t6_data", bus.bin_data, 0);
        chk("t6_idx", 32'(bus.bin_idx), 0);
        chk("t6_last", 32'(bus.bin_last), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_drop", 32'(drop_cnt), 0);
        model_reset();
        @(posedge g_clk); #1;
        g_rst = 1'b0;
        repeat (5) step(0, 0, 1, 1);
        chk("t6_idle", 32'(busy), 0);

        // randomized runs: window, bin count, ready, increments, stray start/abort
        for (int r = 0; r < 40; r++) begin
            win_cycles = WW'($urandom_range(0, 6));
            num_bins   = BW'($urandom_range(0, 4));
            rp  = $urandom_range(30, 100);
            lim = $urandom_range(5, 60);
            if ($urandom_range(0, 3) == 0) photon_cnt = $urandom;
            step(1, 0, ($urandom_range(0, 99) < rp), 1);
            win_cycles = WW'($urandom);
            num_bins   = BW'($urandom);
            for (int c = 0; c < 300 && (m_run || m_drain); c++) begin
                step(($urandom_range(0, 19) == 0),
                     (m_nb == 0 && c == lim) || ($urandom_range(0, 79) == 0),
                     ($urandom_range(0, 99) < rp),
                     ($urandom_range(0, 9) == 0) ? CS'($urandom) : CS'($urandom_range(0, 3)));
            end
            if (m_run || m_drain) step(0, 1, 1, 1);
            repeat (2) step(0, 0, ($urandom_range(0, 1) == 1), 1);
            chk("rnd_sb_drained", 32'(sb.size()), 0);
        end

        repeat (3) step(0, 0, 1, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
